// File: rtl/sccb_responder.sv
// SCCB 3-wire responder: decodes ID / sub-address / data writes into a register file.
// Optional build macro SCCB_ACK_DRIVE_EN drives siod low during the 9th-bit window.
module sccb_responder #(
    parameter logic [7:0] DEV_ID    = 8'h42,
    parameter int         REG_DEPTH = 256,
    parameter logic [7:0] RST_VAL   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc,
    input  logic       siod_in,
    output logic       siod_oe,
    output logic       reg_wr,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] last_sub,
    output logic       phase_done,
    output logic       bus_busy,
    output logic       id_err,
    output logic [2:0] fsm_state
);

    localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

    // IDLE encodes as 0 so the debug state reads 0 whenever the bus is free.
    typedef enum logic [2:0] {
        S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X, S_DATA, S_DATA_X, S_WAIT_STOP
    } state_t;

    state_t     state, state_next;
    logic [1:0] sioc_sync, siod_sync;
    logic       sioc_s, siod_s, sioc_d, siod_d;
    logic       sioc_rise, start_ev, stop_ev, bit_ev, id_ok;
    logic       shift_en, phase_end, err_set, wr_set, sub_cap, sub_keep;
    logic [7:0] sh;
    logic [2:0] bit_cnt;
    logic [7:0] sub_addr;
    logic [7:0] mem [REG_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx;

    // Sync flops idle high so releasing reset on a quiet bus creates no START.
    always_ff @(posedge clk) begin
        if (rst) begin
            sioc_sync <= 2'b11;
            siod_sync <= 2'b11;
            sioc_d    <= 1'b1;
            siod_d    <= 1'b1;
        end else begin
            sioc_sync <= {sioc_sync[0], sioc};
            siod_sync <= {siod_sync[0], siod_in};
            sioc_d    <= sioc_sync[1];
            siod_d    <= siod_sync[1];
        end
    end

    assign sioc_s    = sioc_sync[1];
    assign siod_s    = siod_sync[1];
    assign sioc_rise = sioc_s & ~sioc_d;
    assign start_ev  = ~siod_s & siod_d & sioc_s;
    assign stop_ev   = siod_s & ~siod_d & sioc_s;
    assign id_ok     = (sh == DEV_ID);
    assign wr_idx    = AW'(32'(sub_addr) % REG_DEPTH);
    assign rd_idx    = AW'(32'(rd_addr) % REG_DEPTH);
    assign rd_data   = mem[rd_idx];
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // STOP beats START beats a bit edge; the 8th bit of a phase moves to its _X state.
    always_comb begin
        state_next = state;
        if (stop_ev) begin
            state_next = S_IDLE;
        end else if (start_ev) begin
            state_next = S_ID;
        end else if (sioc_rise) begin
            case (state)
                S_ID:     if (bit_cnt == 3'd7) state_next = S_ID_X;
                S_ID_X:   state_next = id_ok ? S_SUB : S_WAIT_STOP;
                S_SUB:    if (bit_cnt == 3'd7) state_next = S_SUB_X;
                S_SUB_X:  state_next = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_next = S_DATA_X;
                S_DATA_X: state_next = S_WAIT_STOP;
                default:  state_next = state;
            endcase
        end
    end

    // reg_wr is a valid-only strobe (no ready): reg_addr/reg_data hold the committed
    // write for exactly the one cycle reg_wr is high; the consumer cannot stall it.
    always_comb begin
        bit_ev    = sioc_rise & ~start_ev & ~stop_ev;
        shift_en  = bit_ev & (state inside {S_ID, S_SUB, S_DATA});
        phase_end = bit_ev & (state inside {S_ID_X, S_SUB_X, S_DATA_X});
        err_set   = phase_end & (state == S_ID_X) & ~id_ok;
        wr_set    = phase_end & (state == S_DATA_X);
        sub_cap   = phase_end & (state == S_SUB_X);
        sub_keep  = stop_ev & (state == S_DATA);
        bus_busy  = (state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh         <= 8'h00;
            bit_cnt    <= 3'd0;
            sub_addr   <= 8'h00;
            reg_wr     <= 1'b0;
            reg_addr   <= 8'h00;
            reg_data   <= 8'h00;
            last_sub   <= 8'h00;
            phase_done <= 1'b0;
            id_err     <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) mem[i] <= RST_VAL;
        end else begin
            reg_wr     <= wr_set;
            phase_done <= phase_end;
            id_err     <= err_set;
            if (start_ev)      bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en) sh <= {sh[6:0], siod_s};
            if (sub_cap)  sub_addr <= sh;
            if (sub_keep) last_sub <= sub_addr;
            if (wr_set) begin
                reg_addr    <= sub_addr;
                reg_data    <= sh;
                mem[wr_idx] <= sh;
            end
        end
    end

`ifdef SCCB_ACK_DRIVE_EN
    logic sioc_fall, ack_q;
    assign sioc_fall = ~sioc_s & sioc_d;

    // The falling edge after bit 8 opens the window, the one after bit 9 closes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
        end else if (start_ev || stop_ev) begin
            ack_q <= 1'b0;
        end else if (sioc_fall) begin
            ack_q <= ((state == S_ID_X) && id_ok) || (state == S_SUB_X) || (state == S_DATA_X);
        end
    end
    assign siod_oe = ack_q;
`else
    assign siod_oe = 1'b0;
`endif

endmodule

// File: tb/tb_sccb_responder.sv
// Randomized transaction-level bench for sccb_responder with a write scoreboard
// and a register-file model; knows SCCB_ACK_DRIVE_EN for the siod_oe window count.
module tb_sccb_responder;

    localparam logic [7:0] DEV_ID    = 8'h42;
    localparam int         REG_DEPTH = 256;
    localparam logic [7:0] RST_VAL   = 8'h00;
    localparam int         HQ        = 4;   // quarter sioc period in clk cycles
`ifdef SCCB_ACK_DRIVE_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic       clk, rst, sioc, siod_in, siod_oe, reg_wr, phase_done, bus_busy, id_err;
    logic [7:0] reg_addr, reg_data, rd_addr, rd_data, last_sub;
    logic [2:0] fsm_state;

    sccb_responder #(.DEV_ID(DEV_ID), .REG_DEPTH(REG_DEPTH), .RST_VAL(RST_VAL)) dut (
        .clk(clk), .rst(rst), .sioc(sioc), .siod_in(siod_in), .siod_oe(siod_oe),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .last_sub(last_sub),
        .phase_done(phase_done), .bus_busy(bus_busy), .id_err(id_err),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          n_vec = 0, n_err = 0;
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_mem [REG_DEPTH];
    logic [7:0]  exp_last_sub;
    int          exp_pd = 0, exp_err = 0, exp_win = 0;
    int          obs_pd = 0, obs_err = 0, obs_win = 0;
    logic        oe_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops an expected write each time the DUT commits one.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (reg_wr) begin
                    if (exp_wr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_reg_wr: got addr 0x%0h data 0x%0h, want no write",
                                 reg_addr, reg_data);
                    end else begin
                        e = exp_wr_q.pop_front();
                        chk("reg_wr_addr_data", int'({reg_addr, reg_data}), int'(e));
                    end
                end
                if (phase_done) obs_pd++;
                if (id_err) obs_err++;
                if (siod_oe && !oe_prev) obs_win++;
            end
            oe_prev = siod_oe;
        end
    end

    // ---------------- bus driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start;
        sioc = 1'b0; wait_clk(HQ);
        siod_in = 1'b1; wait_clk(HQ);
        sioc = 1'b1; wait_clk(2 * HQ);
        siod_in = 1'b0; wait_clk(2 * HQ);
        sioc = 1'b0; wait_clk(HQ);
    endtask

    task automatic send_bit(input logic b);
        siod_in = b; wait_clk(HQ);
        sioc = 1'b1; wait_clk(2 * HQ);
        sioc = 1'b0; wait_clk(HQ);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
        send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic bus_stop;
        siod_in = 1'b0; wait_clk(HQ);
        sioc = 1'b1; wait_clk(2 * HQ);
        siod_in = 1'b1; wait_clk(4 * HQ);
    endtask

    task automatic check_rd(input string name, input logic [7:0] a);
        rd_addr = a;
        #1;
        chk(name, int'(rd_data), int'(exp_mem[int'(a) % REG_DEPTH]));
    endtask

    task automatic end_check(input logic [7:0] a);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("phase_done_count", obs_pd, exp_pd);
        chk("id_err_count", obs_err, exp_err);
        chk("ack_windows", obs_win, ACK_EN ? exp_win : 0);
        chk("bus_busy_after_stop", int'(bus_busy), 0);
        chk("fsm_idle_after_stop", int'(fsm_state), 0);
        chk("last_sub", int'(last_sub), int'(exp_last_sub));
        check_rd("rd_data_touched", a);
        check_rd("rd_data_random", 8'($urandom));
    endtask

    // ---------------- transaction-level reference model + stimulus ----------------
    task automatic full_write(input logic [7:0] id, input logic [7:0] sub, input logic [7:0] data);
        if (id == DEV_ID) begin
            exp_wr_q.push_back({sub, data});
            exp_mem[int'(sub) % REG_DEPTH] = data;
            exp_pd += 3;
            exp_win += 3;
        end else begin
            exp_err++;
            exp_pd++;
        end
        bus_start;
        send_byte(id);
        send_byte(sub);
        send_byte(data);
        bus_stop;
        wait_clk(8);
        end_check(sub);
    endtask

    task automatic two_phase(input logic [7:0] id, input logic [7:0] sub);
        if (id == DEV_ID) begin
            exp_last_sub = sub;
            exp_pd += 2;
            exp_win += 2;
        end else begin
            exp_err++;
            exp_pd++;
        end
        bus_start;
        send_byte(id);
        send_byte(sub);
        bus_stop;
        wait_clk(8);
        end_check(sub);
    endtask

    // Matched ID + sub, then k (<= 6) data bits; the caller follows up with a START.
    task automatic data_prefix(input logic [7:0] sub, input logic [7:0] data, input int k);
        exp_pd += 2;
        exp_win += 2;
        bus_start;
        send_byte(DEV_ID);
        send_byte(sub);
        for (int i = 0; i < k; i++) send_bit(data[7 - i]);
    endtask

    task automatic reset_model;
        for (int i = 0; i < REG_DEPTH; i++) exp_mem[i] = RST_VAL;
        exp_last_sub = 8'h00;
    endtask

    task automatic check_reset_outputs;
        chk("rst_reg_wr", int'(reg_wr), 0);
        chk("rst_phase_done", int'(phase_done), 0);
        chk("rst_id_err", int'(id_err), 0);
        chk("rst_bus_busy", int'(bus_busy), 0);
        chk("rst_siod_oe", int'(siod_oe), 0);
        chk("rst_reg_addr", int'(reg_addr), 0);
        chk("rst_reg_data", int'(reg_data), 0);
        chk("rst_last_sub", int'(last_sub), 0);
        chk("rst_fsm_idle", int'(fsm_state), 0);
    endtask

    initial begin
        logic [7:0] id, sub, data;
        int         sel, k;
        rst = 1'b1; sioc = 1'b1; siod_in = 1'b1; rd_addr = 8'h00;
        reset_model();
        wait_clk(5);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        check_rd("rst_rd_0x12", 8'h12);
        check_rd("rst_rd_0xff", 8'hFF);
        wait_clk(4);

        full_write(8'h42, 8'h12, 8'h80);          // basic commit
        full_write(8'h44, 8'h12, 8'h55);          // ID mismatch, no write
        two_phase(8'h42, 8'h0A);                  // 2-phase write loads last_sub

        // reset in the middle of the data phase
        data_prefix(8'h12, 8'h33, 4);
        wait_clk(6);
        rst = 1'b1;
        reset_model();
        wait_clk(3);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        check_rd("rst_mid_rd_0x12", 8'h12);
        wait_clk(4);
        full_write(8'h42, 8'h12, 8'h33);

        // repeated START inside the data phase
        data_prefix(8'h5C, 8'h99, 3);
        full_write(8'h42, 8'h3A, 8'h04);
        check_rd("restart_dropped_0x5c", 8'h5C);

        for (int t = 0; t < 30; t++) begin
            sel  = $urandom_range(0, 9);
            sub  = 8'($urandom);
            data = 8'($urandom);
            if (sel <= 4) begin
                full_write(DEV_ID, sub, data);
            end else if (sel <= 6) begin
                do id = 8'($urandom); while (id == DEV_ID);
                full_write(id, sub, data);
            end else if (sel <= 8) begin
                if ($urandom_range(0, 3) == 0) begin
                    do id = 8'($urandom); while (id == DEV_ID);
                end else begin
                    id = DEV_ID;
                end
                two_phase(id, sub);
            end else begin
                k = $urandom_range(0, 6);
                data_prefix(sub, data, k);
                full_write(DEV_ID, 8'($urandom), 8'($urandom));
                check_rd("restart_dropped_rand", sub);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
